// File: rtl/cplx_pkg.sv
// Shared types and constant helpers for the sequential complex divider.
package cplx_pkg;

  typedef enum logic [2:0] {IDLE, PREP, DIV, FIN, DONE} state_e;

  // Dividend width and iteration count of the restoring dividers.
  function automatic int QW(input int n, input int f);
    return 2 * n + f;
  endfunction

  function automatic int OW(input int n);
    return 2 * n;
  endfunction

  function automatic longint SAT_MAX(input int ow);
    return (longint'(1) <<< (ow - 1)) - 1;
  endfunction

  function automatic longint SAT_MIN(input int ow);
    return -(longint'(1) <<< (ow - 1));
  endfunction

endpackage

// File: rtl/cplx_div_seq_udiv.sv
// Unsigned restoring divider: load captures operands, each step retires one quotient bit.
module udiv_seq #(
  parameter int DW = 24,
  parameter int VW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          step,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic [DW-1:0] quot
);

  logic [VW-1:0] rem_q, rem_d;
  logic [DW-1:0] quo_q, quo_d;
  logic [VW-1:0] dvs_q, dvs_d;
  logic [VW:0]   shifted;
  logic          ge;

  // The quotient register doubles as the dividend shifter: its MSB feeds the remainder.
  assign shifted = {rem_q, quo_q[DW-1]};
  assign ge      = shifted >= {1'b0, dvs_q};

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    rem_d = rem_q;
    quo_d = quo_q;
    dvs_d = dvs_q;
    if (load) begin
      rem_d = '0;
      quo_d = dividend;
      dvs_d = divisor;
    end else if (step) begin
      rem_d = ge ? (shifted[VW-1:0] - dvs_q) : shifted[VW-1:0];
      quo_d = {quo_q[DW-2:0], ge};
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, reset asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
    end
  end

  assign quot = quo_q;

endmodule

// File: rtl/cplx_div_seq.sv
// Sequential complex divider q = a / b: a*conj(b) / |b|^2 through two parallel restoring dividers.
module cplx_div_seq
  import cplx_pkg::*;
#(
  parameter int N = 8,
  parameter int F = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [N-1:0] a_r,
  input  logic signed [N-1:0] a_i,
  input  logic signed [N-1:0] b_r,
  input  logic signed [N-1:0] b_i,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2*N-1:0]      q_r,
  output logic [2*N-1:0]      q_i,
  output logic                ovf,
  output logic                dz
);

  localparam int QWL = QW(N, F);
  localparam int OWL = OW(N);
  localparam int PW  = 2 * N;
  localparam int QV  = QWL + 1;
  localparam int CW  = $clog2(QWL);
  localparam logic signed [QV-1:0] SMAX = QV'(SAT_MAX(OWL));
  localparam logic signed [QV-1:0] SMIN = QV'(SAT_MIN(OWL));

  state_e              state_q, state_d;
  logic signed [N-1:0] ar_q, ar_d, ai_q, ai_d, br_q, br_d, bi_q, bi_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                sgn_r_q, sgn_r_d, sgn_i_q, sgn_i_d;
  logic [OWL-1:0]      q_r_q, q_r_d, q_i_q, q_i_d;
  logic                ovf_q, ovf_d, dz_q, dz_d;

  logic signed [PW-1:0] p_rr, p_ii, p_ir, p_ri, p_bb_r, p_bb_i;
  logic signed [PW:0]   num_r, num_i;
  logic [PW-1:0]        den, mag_r, mag_i;
  logic [QWL-1:0]       quot_r, quot_i;
  logic [OWL:0]         sat_r, sat_i;
  logic                 div_load, div_step;

  // Returns {clamped, value}; truncation toward zero comes from dividing magnitudes.
  function automatic logic [OWL:0] saturate(input logic neg, input logic [QWL-1:0] mag);
    logic signed [QV-1:0] v;
    v = neg ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
    if (v > SMAX)      return {1'b1, SMAX[OWL-1:0]};
    else if (v < SMIN) return {1'b1, SMIN[OWL-1:0]};
    return {1'b0, v[OWL-1:0]};
  endfunction

  assign p_rr   = ar_q * br_q;
  assign p_ii   = ai_q * bi_q;
  assign p_ir   = ai_q * br_q;
  assign p_ri   = ar_q * bi_q;
  assign p_bb_r = br_q * br_q;
  assign p_bb_i = bi_q * bi_q;
  assign num_r  = {p_rr[PW-1], p_rr} + {p_ii[PW-1], p_ii};
  assign num_i  = {p_ir[PW-1], p_ir} - {p_ri[PW-1], p_ri};
  assign den    = $unsigned(p_bb_r) + $unsigned(p_bb_i);
  assign mag_r  = PW'(num_r[PW] ? -num_r : num_r);
  assign mag_i  = PW'(num_i[PW] ? -num_i : num_i);

  assign div_load = (state_q == PREP);
  assign div_step = (state_q == DIV);

  udiv_seq #(.DW(QWL), .VW(PW)) u_div_r (
    .clk(clk), .rst_n(rst_n), .load(div_load), .step(div_step),
    .dividend({mag_r, {F{1'b0}}}), .divisor(den), .quot(quot_r)
  );

  udiv_seq #(.DW(QWL), .VW(PW)) u_div_i (
    .clk(clk), .rst_n(rst_n), .load(div_load), .step(div_step),
    .dividend({mag_i, {F{1'b0}}}), .divisor(den), .quot(quot_i)
  );

  assign sat_r = saturate(sgn_r_q, quot_r);
  assign sat_i = saturate(sgn_i_q, quot_i);

  always_comb begin
    state_d = state_q;
    ar_d    = ar_q;
    ai_d    = ai_q;
    br_d    = br_q;
    bi_d    = bi_q;
    cnt_d   = cnt_q;
    sgn_r_d = sgn_r_q;
    sgn_i_d = sgn_i_q;
    q_r_d   = q_r_q;
    q_i_d   = q_i_q;
    ovf_d   = ovf_q;
    dz_d    = dz_q;
    unique case (state_q)
      IDLE: if (in_valid) begin
        ar_d    = a_r;
        ai_d    = a_i;
        br_d    = b_r;
        bi_d    = b_i;
        state_d = PREP;
      end
      PREP: begin
        sgn_r_d = num_r[PW];
        sgn_i_d = num_i[PW];
        if (den == '0) begin
          q_r_d   = '0;
          q_i_d   = '0;
          ovf_d   = 1'b0;
          dz_d    = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d   = CW'(QWL - 1);
          state_d = DIV;
        end
      end
      DIV: begin
        if (cnt_q == '0) state_d = FIN;
        else             cnt_d   = cnt_q - 1'b1;
      end
      FIN: begin
        q_r_d   = sat_r[OWL-1:0];
        q_i_d   = sat_i[OWL-1:0];
        ovf_d   = sat_r[OWL] | sat_i[OWL];
        dz_d    = 1'b0;
        state_d = DONE;
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ar_q    <= '0;
      ai_q    <= '0;
      br_q    <= '0;
      bi_q    <= '0;
      cnt_q   <= '0;
      sgn_r_q <= 1'b0;
      sgn_i_q <= 1'b0;
      q_r_q   <= '0;
      q_i_q   <= '0;
      ovf_q   <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ar_q    <= ar_d;
      ai_q    <= ai_d;
      br_q    <= br_d;
      bi_q    <= bi_d;
      cnt_q   <= cnt_d;
      sgn_r_q <= sgn_r_d;
      sgn_i_q <= sgn_i_d;
      q_r_q   <= q_r_d;
      q_i_q   <= q_i_d;
      ovf_q   <= ovf_d;
      dz_q    <= dz_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign q_r       = q_r_q;
  assign q_i       = q_i_q;
  assign ovf       = ovf_q;
  assign dz        = dz_q;

endmodule

// File: tb/tb_cplx_div_seq.sv
// Directed bench for cplx_div_seq: vector table plus backpressure and mid-operation reset sequences.
module tb_cplx_div_seq;

  localparam int N  = 8;
  localparam int F  = 8;
  localparam int OW = 2 * N;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 out_ready = 1'b0;
  logic signed [N-1:0]  a_r = '0, a_i = '0, b_r = '0, b_i = '0;
  logic                 in_ready, out_valid, ovf, dz;
  logic signed [OW-1:0] q_r, q_i;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cplx_div_seq #(.N(N), .F(F)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a_r(a_r), .a_i(a_i), .b_r(b_r), .b_i(b_i),
    .out_valid(out_valid), .out_ready(out_ready),
    .q_r(q_r), .q_i(q_i), .ovf(ovf), .dz(dz)
  );

  typedef struct {
    logic signed [7:0] ar, ai, br, bi;
    int                qr, qi;
    int                ovf, dz, lat;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  // Called #1 after a rising edge; presents operands for exactly one edge.
  task automatic start_op(input logic signed [7:0] ar, ai, br, bi);
    a_r = ar; a_i = ai; b_r = br; b_i = bi;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!out_valid && lat < 60);
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int lat;
    check({tag, "_in_ready"}, in_ready, 1);
    start_op(v.ar, v.ai, v.br, v.bi);
    wait_result(lat);
    check({tag, "_latency"}, lat, v.lat);
    check({tag, "_q_r"}, q_r, v.qr);
    check({tag, "_q_i"}, q_i, v.qi);
    check({tag, "_ovf"}, ovf, v.ovf);
    check({tag, "_dz"}, dz, v.dz);
    handshake();
    check({tag, "_out_valid_clr"}, out_valid, 0);
  endtask

  initial begin
    int seen;

    vecs[0]  = '{ 8'sd4,    8'sd2,    8'sd1,   8'sd1,    768,  -256, 0, 0, 26};
    vecs[1]  = '{ 8'sd1,    8'sd0,    8'sd3,   8'sd0,     85,     0, 0, 0, 26};
    vecs[2]  = '{-8'sd1,    8'sd0,    8'sd3,   8'sd0,    -85,     0, 0, 0, 26};
    vecs[3]  = '{-8'sd128, -8'sd128,  8'sd0,   8'sd1, -32768, 32767, 1, 0, 26};
    vecs[4]  = '{ 8'sd5,   -8'sd7,    8'sd0,   8'sd0,      0,     0, 0, 1,  1};
    vecs[5]  = '{ 8'sd0,    8'sd0,    8'sd3,   8'sd4,      0,     0, 0, 0, 26};
    vecs[6]  = '{ 8'sd3,    8'sd4,    8'sd3,   8'sd4,    256,     0, 0, 0, 26};
    vecs[7]  = '{ 8'sd10,  -8'sd20,   8'sd2,  -8'sd1,   2048, -1536, 0, 0, 26};
    vecs[8]  = '{ 8'sd127,  8'sd127,  8'sd1,   8'sd0,  32512, 32512, 0, 0, 26};
    vecs[9]  = '{-8'sd128,  8'sd0,   -8'sd1,   8'sd0,  32767,     0, 1, 0, 26};
    vecs[10] = '{ 8'sd7,    8'sd0,   -8'sd2,   8'sd3,   -275,  -413, 0, 0, 26};

    repeat (2) @(posedge clk); #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_q_r", q_r, 0);
    check("rst_q_i", q_i, 0);
    check("rst_ovf", ovf, 0);
    check("rst_dz", dz, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Backpressure: result held while a competing request is presented.
    begin
      int lat;
      start_op(8'sd4, 8'sd2, 8'sd1, 8'sd1);
      wait_result(lat);
      check("bp_latency", lat, 26);
      a_r = 8'sd1; a_i = 8'sd0; b_r = 8'sd3; b_i = 8'sd0;
      in_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
        @(posedge clk); #1;
        check($sformatf("bp%0d_out_valid", k), out_valid, 1);
        check($sformatf("bp%0d_in_ready", k), in_ready, 0);
        check($sformatf("bp%0d_q_r", k), q_r, 768);
        check($sformatf("bp%0d_q_i", k), q_i, -256);
      end
      in_valid = 1'b0;
      handshake();
      check("bp_in_ready_after", in_ready, 1);
      check("bp_out_valid_after", out_valid, 0);
      check("bp_q_r_hold", q_r, 768);
      @(posedge clk); #1;
      check("bp_not_taken", in_ready, 1);
      run_vec(vecs[10], "bp_next");
    end

    // Reset during DIV: abort with no result, then a fresh operation.
    start_op(8'sd10, -8'sd20, 8'sd2, -8'sd1);
    repeat (10) @(posedge clk); #1;
    check("mid_busy", in_ready, 0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_q_r", q_r, 0);
    check("mid_rst_q_i", q_i, 0);
    check("mid_rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1;
    end
    check("mid_no_stale", seen, 0);
    run_vec(vecs[1], "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cplx_div_seq.md
Name: cplx_div_seq

Overview:
- Sequential complex divider, the inverse operation of the team's complex multiplier: q = a / b, with complex operands in signed fixed-point.
- Computes num = a·conj(b) and den = |b|², then runs two parallel restoring dividers, one for the real part and one for the imaginary part.
- Valid/ready handshake on the input and output sides, so it drops into the same datapaths as the multiplier blocks.

Parameters:
- N, 8, width of each signed input component.
- F, 8, number of fractional bits in the quotient; q = trunc(num·2^F / den).
- Derived: QW = 2N+F is the dividend width and the iteration count. OW = 2N is the signed output width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- in_valid  in  1  operands are valid.
- in_ready  out  1  block can accept operands.
- a_r, a_i  in  N  signed numerator, real and imaginary.
- b_r, b_i  in  N  signed denominator, real and imaginary.
- out_valid  out  1  result is valid.
- out_ready  in  1  downstream accepts the result.
- q_r, q_i  out  OW  signed quotient, F fractional bits.
- ovf  out  1  one or both parts saturated.
- dz  out  1  divide by zero (b = 0).

Behaviour:
- Reset (async, rst_n=0): state=IDLE; in_ready=1; out_valid=0; q_r=q_i=0; ovf=dz=0; internal counters and registers cleared. Reset mid-operation aborts the operation with no output.
- States: IDLE, PREP, DIV, FIN, DONE.
- in_ready=1 only in IDLE. Acceptance occurs at edge E when in_valid & in_ready; operands are captured and the state moves to PREP.
- PREP (edge E+1):
  - num_r = a_r·b_r + a_i·b_i and num_i = a_i·b_r − a_r·b_i, both 2N+1 bits signed.
  - den = b_r² + b_i², 2N bits unsigned.
  - Signs are stored; magnitudes are loaded as the dividend |num|<<F.
  - If den==0: go to DONE with q_r=q_i=0, dz=1, ovf=0.
  - Otherwise: go to DIV with iteration counter = QW−1.
- DIV: one restoring-division step per cycle for both dividers in parallel (shift, trial-subtract den, set quotient bit). After QW steps (edges E+2..E+QW+1) go to FIN.
- FIN (edge E+QW+2):
  - Reapply sign to each magnitude quotient, so rounding is truncation toward zero.
  - Saturate each part to OW bits signed. A positive part exceeding 2^(OW−1)−1 clamps to 2^(OW−1)−1. A negative part below −2^(OW−1) clamps to −2^(OW−1); exactly −2^(OW−1) is not an overflow.
  - ovf = OR of both clamp events.
  - Register q_r, q_i, ovf, dz=0; go to DONE.
- out_valid=1 only in DONE:
  - Rises at E+QW+2 in the normal case (E+26 for defaults) and at E+1 on divide-by-zero.
  - q_r, q_i, ovf, dz are stable while out_valid=1 and out_ready=0.
  - out_valid & out_ready at an edge → IDLE, out_valid=0. Outputs hold their last values (not cleared).
- in_valid while busy is ignored (not latched). No back-to-back overlap: the next acceptance occurs at the earliest one edge after result handoff.
- Zero numerator → q=0, ovf=0, dz=0, full normal latency.

Decomposition:
- Shared package cplx_pkg: state enum type; helper constant functions QW(N,F) and OW(N); saturation limits SAT_MAX and SAT_MIN.
- Sub-module udiv_seq #(DW=QW, VW=2N): unsigned restoring divider with load/step controls; instantiated twice (real, imaginary). The top level holds the FSM, PREP arithmetic, and sign/saturation logic.

Test Plan:
- Basic: a=(4,2), b=(1,1) → q_r=768 (0x0300), q_i=−256 (0xFF00), ovf=0, dz=0, out_valid exactly 26 cycles after acceptance.
- Truncation: a=(1,0), b=(3,0) → q_r=85, q_i=0. a=(−1,0), b=(3,0) → q_r=−85.
- Saturation: a=(−128,−128), b=(0,1) → q_r=−32768 (exact, not clamped), q_i=32767, ovf=1.
- Divide-by-zero: b=(0,0), a=(5,−7) → q_r=q_i=0, dz=1, out_valid one cycle after acceptance.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid with in_valid=1 and different operands → outputs stable, in_ready=0, new operands not taken; after the handshake, in_ready=1 and the next result is correct.
- Reset mid-DIV: assert rst_n=0 ten cycles after acceptance → out_valid=0, q=0, in_ready=1 immediately. No stale result appears after release. A fresh operation completes correctly.
